// File: rtl/add_sub_bist_pkg.sv
// Shared types and constants for the add/sub BIST engine: state encoding,
// per-width LFSR tap masks and the counter width.
package add_sub_bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } bist_state_e;

  localparam int CNT_W = 16;

  // Fibonacci taps as bit masks (tap n -> bit n-1)
  localparam logic [8:0]  TAPS_W4  = 9'h110;
  localparam logic [16:0] TAPS_W8  = 17'h1_2000;
  localparam logic [32:0] TAPS_W16 = 33'h1_0008_0000;

  function automatic logic [32:0] tap_mask(input int width);
    case (width)
      8:       return {16'd0, TAPS_W8};
      16:      return TAPS_W16;
      default: return {24'd0, TAPS_W4};
    endcase
  endfunction

endpackage

// File: rtl/bist_lfsr.sv
// Shift-left Fibonacci LFSR; the feedback bit is the XOR of the masked taps.
module bist_lfsr #(
  parameter int          N    = 9,
  parameter logic [N-1:0] TAPS = 9'h110
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         advance,
  input  logic [N-1:0] seed,
  output logic [N-1:0] q_next
);

  logic [N-1:0] q;
  logic         fb;

  assign fb     = ^(q & TAPS);
  assign q_next = {q[N-2:0], fb};

  always_ff @(posedge clk) begin
    if (rst)          q <= seed;
    else if (load)    q <= seed;
    else if (advance) q <= q_next;
  end

endmodule

// File: rtl/add_sub_bist.sv
// Self-test engine for the CLA adder/subtractor: LFSR vectors out, golden compare in.
// Optional build macro BIST_STOP_ON_FAIL_EN ends the run on the first mismatch.
module add_sub_bist
  import add_sub_bist_pkg::*;
#(
  parameter int                 WIDTH       = 4,
  parameter int                 NUM_VECTORS = 1000,
  parameter logic [2*WIDTH:0]   SEED        = 9'h1A5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [CNT_W-1:0]   err_count,
  output logic [CNT_W-1:0]   vec_count,
  output logic [WIDTH-1:0]   dut_A,
  output logic [WIDTH-1:0]   dut_B,
  output logic               dut_sub,
  input  logic [WIDTH-1:0]   dut_Sum,
  input  logic               dut_pos_Ovfl,
  input  logic               dut_neg_Ovfl,
  output logic [2*WIDTH:0]   fail_vec
);

  localparam int              VW       = 2*WIDTH + 1;
  localparam logic [32:0]     TAP_FULL = tap_mask(WIDTH);
  localparam logic [VW-1:0]   TAPS     = TAP_FULL[VW-1:0];
  localparam logic [VW-1:0]   SEED_EFF = (SEED == '0) ? VW'(1) : SEED;
  localparam logic [CNT_W:0]  NV       = (CNT_W+1)'(NUM_VECTORS);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  bist_state_e       state_q, state_d;
  logic [VW-1:0]     vec_q, lfsr_next, fail_vec_q;
  logic [CNT_W-1:0]  vec_count_q, err_count_q;
  logic              busy_q;
  logic              lfsr_load, lfsr_adv;

  logic [WIDTH-1:0]  vec_a, vec_b, bx, exp_sum;
  logic              vec_sub, exp_pos, exp_neg, mismatch, last_vec;

  assign vec_a   = vec_q[VW-1 -: WIDTH];
  assign vec_b   = vec_q[WIDTH:1];
  assign vec_sub = vec_q[0];

  bist_lfsr #(.N(VW), .TAPS(TAPS)) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (lfsr_load),
    .advance (lfsr_adv),
    .seed    (SEED_EFF),
    .q_next  (lfsr_next)
  );

  always_comb begin
    state_d   = state_q;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;
    bx        = vec_sub ? ~vec_b : vec_b;
    exp_sum   = vec_a + bx + WIDTH'(vec_sub);
    exp_pos   = ~vec_a[WIDTH-1] & ~bx[WIDTH-1] &  exp_sum[WIDTH-1];
    exp_neg   =  vec_a[WIDTH-1] &  bx[WIDTH-1] & ~exp_sum[WIDTH-1];
    // Stays set unless every compare is a definite 1, so X/Z inputs count as failures
    mismatch  = 1'b1;
    if ((dut_Sum == exp_sum) && (dut_pos_Ovfl == exp_pos) && (dut_neg_Ovfl == exp_neg))
      mismatch = 1'b0;
    last_vec  = (({1'b0, vec_count_q}) + (CNT_W+1)'(1)) == NV;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = APPLY;
          lfsr_load = 1'b1;
        end
      end
      APPLY: state_d = CHECK;
      CHECK: begin
        if (last_vec) state_d = DONE;
`ifdef BIST_STOP_ON_FAIL_EN
        else if (mismatch) state_d = DONE;
`endif
        else begin
          state_d  = APPLY;
          lfsr_adv = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      vec_q       <= '0;
      vec_count_q <= '0;
      err_count_q <= '0;
      fail_vec_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (lfsr_load) begin
        vec_q       <= SEED_EFF;
        vec_count_q <= '0;
        err_count_q <= '0;
        fail_vec_q  <= '0;
        busy_q      <= 1'b0;
      end
      if (lfsr_adv) vec_q <= lfsr_next;
      // busy rises one edge after the start edge and falls on the finishing edge
      if (state_q == APPLY) busy_q <= 1'b1;
      if (state_q == CHECK) begin
        if (vec_count_q != CNT_MAX) vec_count_q <= vec_count_q + CNT_W'(1);
        if (mismatch) begin
          if (err_count_q == '0)     fail_vec_q  <= vec_q;
          if (err_count_q != CNT_MAX) err_count_q <= err_count_q + CNT_W'(1);
        end
        if (state_d == DONE) busy_q <= 1'b0;
      end
    end
  end

  assign busy      = busy_q;
  assign done      = (state_q == DONE);
  assign pass      = done & (err_count_q == '0);
  assign err_count = err_count_q;
  assign vec_count = vec_count_q;
  assign dut_A     = vec_a;
  assign dut_B     = vec_b;
  assign dut_sub   = vec_sub;
  assign fail_vec  = fail_vec_q;

endmodule

// File: tb/tb_add_sub_bist.sv
// Bench for add_sub_bist: behavioural adder with fault modes, run-level model, per-cycle compare.
module tb_add_sub_bist;

  localparam int         NV   = 16;
  localparam logic [8:0] SEED = 9'h1A5;
`ifdef BIST_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  localparam int M_NONE = 0, M_SUM0 = 1, M_POS0 = 2, M_NEG0 = 3, M_X = 4;

  logic        clk = 1'b0;
  logic        rst, start;
  logic        busy, done, pass;
  logic [15:0] err_count, vec_count;
  logic [3:0]  dut_A, dut_B, add_sum;
  logic        dut_sub, add_pos, add_neg;
  logic [8:0]  fail_vec;
  int          mode = M_NONE;
  bit          chk_en = 1'b0;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  add_sub_bist #(.WIDTH(4), .NUM_VECTORS(NV), .SEED(SEED)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .err_count    (err_count),
    .vec_count    (vec_count),
    .dut_A        (dut_A),
    .dut_B        (dut_B),
    .dut_sub      (dut_sub),
    .dut_Sum      (add_sum),
    .dut_pos_Ovfl (add_pos),
    .dut_neg_Ovfl (add_neg),
    .fail_vec     (fail_vec)
  );

  // Adder under test: two's-complement arithmetic with optional planted faults
  logic signed [3:0] sa, sb;
  int                r;
  always_comb begin
    sa = dut_A;
    sb = dut_B;
    r  = dut_sub ? (int'(sa) - int'(sb)) : (int'(sa) + int'(sb));
    add_sum = 4'(r);
    add_pos = (r > 7);
    add_neg = (r < -8);
    case (mode)
      M_SUM0:  add_sum[0] = 1'b0;
      M_POS0:  add_pos = 1'b0;
      M_NEG0:  add_neg = 1'b0;
      M_X:     add_sum = 'x;
      default: ;
    endcase
  end

  // Whether the fault mode makes vector v disagree with true arithmetic
  function automatic bit vec_bad(input logic [8:0] v, input int md);
    logic signed [3:0] a, b;
    int rr;
    a  = v[8:5];
    b  = v[4:1];
    rr = v[0] ? (int'(a) - int'(b)) : (int'(a) + int'(b));
    case (md)
      M_SUM0:  return rr[0];
      M_POS0:  return rr > 7;
      M_NEG0:  return rr < -8;
      M_X:     return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  logic [8:0] vecs [0:63];
  initial begin
    logic [8:0] x;
    x = SEED;
    for (int i = 0; i < 64; i++) begin
      vecs[i] = x;
      x = {x[7:0], x[8] ^ x[4]};
    end
  end

  // Run-level model: m_t counts edges since the accepted start
  bit         m_run = 1'b0, m_done = 1'b0;
  int         m_t = 0, m_vc = 0, m_ec = 0;
  logic [8:0] m_fv = '0, m_vec = '0;

  always @(posedge clk) begin
    bit         run, dn, bad;
    int         t, vc, ec, idx;
    logic [8:0] fv, cur;
    run = m_run; dn = m_done; t = m_t; vc = m_vc; ec = m_ec; fv = m_fv; cur = m_vec;
    if (rst) begin
      run = 0; dn = 0; t = 0; vc = 0; ec = 0; fv = '0; cur = '0;
    end else if (run) begin
      t++;
      if (t % 2 == 0) begin
        idx = t / 2 - 1;
        bad = vec_bad(vecs[idx], mode);
        if (vc < 65535) vc++;
        if (bad) begin
          if (ec == 0) fv = vecs[idx];
          if (ec < 65535) ec++;
        end
        if (vc == NV || (STOP && bad)) begin
          run = 0; dn = 1;
        end else cur = vecs[idx+1];
      end
    end else if (start) begin
      run = 1; dn = 0; t = 0; vc = 0; ec = 0; fv = '0; cur = vecs[0];
    end
    m_run <= run; m_done <= dn; m_t <= t; m_vc <= vc; m_ec <= ec; m_fv <= fv; m_vec <= cur;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy",      32'(busy),      32'(m_run && m_t >= 1));
      check("done",      32'(done),      32'(m_done));
      check("pass",      32'(pass),      32'(m_done && m_ec == 0));
      check("vec_count", 32'(vec_count), 32'(m_vc));
      check("err_count", 32'(err_count), 32'(m_ec));
      check("fail_vec",  32'(fail_vec),  32'(m_fv));
      check("dut_vec",   32'({dut_A, dut_B, dut_sub}), 32'(m_vec));
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic fault_run(input int md, input int exp_err, input logic [8:0] exp_fv,
                           input int stop_vc, input string tag);
    mode = md;
    pulse_start();
    check({tag, "_done_drop"}, 32'(done), 32'(0));
    repeat (32) @(negedge clk);
    check({tag, "_done"},     32'(done),      32'(1));
    check({tag, "_pass"},     32'(pass),      32'(0));
    check({tag, "_fail_vec"}, 32'(fail_vec),  32'(exp_fv));
    check({tag, "_err"},      32'(err_count), STOP ? 32'(1) : 32'(exp_err));
    check({tag, "_vc"},       32'(vec_count), STOP ? 32'(stop_vc) : 32'(NV));
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_outputs", {8'd0, busy, done, pass, err_count[4:0], vec_count[4:0],
                          dut_A, dut_B, dut_sub, fail_vec[3:0]}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Clean adder, full run
    pulse_start();
    check("r1_first_vec", 32'({dut_A, dut_B, dut_sub}), 32'(9'h1A5));
    check("r1_busy_e0",   32'(busy), 32'(0));
    @(negedge clk);
    check("r1_busy_e1",   32'(busy), 32'(1));
    repeat (30) @(negedge clk);
    check("r1_done_e31",  32'(done), 32'(0));
    @(negedge clk);
    check("r1_done_e32",  32'(done), 32'(1));
    check("r1_pass",      32'(pass), 32'(1));
    check("r1_vc",        32'(vec_count), 32'(16));
    check("r1_err",       32'(err_count), 32'(0));

    fault_run(M_SUM0, 8, 9'h1A5, 1, "sum0");
    fault_run(M_POS0, 1, 9'h097, 3, "pos0");
    fault_run(M_NEG0, 2, 9'h14B, 2, "neg0");
    fault_run(M_X,   16, 9'h1A5, 1, "xsum");

    // Reset while vector 5 is in CHECK, then rerun from the seed
    mode = M_NONE;
    pulse_start();
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_busy", 32'(busy), 32'(0));
    check("rst_mid_vc",   32'(vec_count), 32'(0));
    check("rst_mid_vec",  32'({dut_A, dut_B, dut_sub}), 32'(0));
    @(negedge clk);
    pulse_start();
    check("r6_first_vec", 32'({dut_A, dut_B, dut_sub}), 32'(9'h1A5));
    repeat (5) @(negedge clk);
    pulse_start();
    repeat (25) @(negedge clk);
    check("r6_done_e31", 32'(done), 32'(0));
    @(negedge clk);
    check("r6_done_e32", 32'(done), 32'(1));
    check("r6_vc",       32'(vec_count), 32'(16));
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
